// File: rtl/axis_i2s2_tx_arb.sv
// axis_i2s2_tx_arb
// Packet-granular arbiter that shares the I2S controller transmit stream
// between two stereo sample sources. A whole packet is granted to one
// source at a time. The output is a one-deep registered slice. Packet length
// violations are repaired on the output and recorded in a sticky err_len flag.
//
// Build option: define AXIS_I2S2_TX_ARB_FIXED_PRIO_EN to give s0 fixed
// priority on simultaneous requests. The default is round-robin.
module axis_i2s2_tx_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_WORDS  = 2
) (
  input  logic                  axis_clk,
  input  logic                  axis_reset,
  input  logic [DATA_WIDTH-1:0] s0_axis_data,
  input  logic                  s0_axis_valid,
  output logic                  s0_axis_ready,
  input  logic                  s0_axis_last,
  input  logic [DATA_WIDTH-1:0] s1_axis_data,
  input  logic                  s1_axis_valid,
  output logic                  s1_axis_ready,
  input  logic                  s1_axis_last,
  input  logic [1:0]            src_enable,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  output logic [1:0]            grant,
  output logic                  err_len,
  input  logic                  err_clear
);

  localparam int CNT_W = $clog2(PKT_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_WORDS);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]            state;
  logic [CNT_W-1:0]      word_cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic [1:0]            req;
  logic                  win;
  logic                  slice_free;
  logic                  accept;
  logic [DATA_WIDTH-1:0] acc_data;
  logic                  acc_last;
  logic                  full_cnt;
  logic                  pkt_end;
  logic                  err_set;

  // Ready depends only on the grant register and downstream ready, never on source valid.
  assign slice_free    = !m_axis_valid | m_axis_ready;
  assign s0_axis_ready = grant[0] & slice_free;
  assign s1_axis_ready = grant[1] & slice_free;
  assign req           = {s1_axis_valid & src_enable[1], s0_axis_valid & src_enable[0]};

  // Select the granted source and decide whether this accept closes the packet or breaks its length.
  always_comb begin
    accept   = (s0_axis_valid & s0_axis_ready) | (s1_axis_valid & s1_axis_ready);
    acc_data = grant[1] ? s1_axis_data : s0_axis_data;
    acc_last = grant[1] ? s1_axis_last : s0_axis_last;
    cnt_next = word_cnt + 1'b1;
    full_cnt = (cnt_next == LAST_CNT);
    pkt_end  = accept & (acc_last | full_cnt);
    err_set  = accept & ((acc_last & (cnt_next < LAST_CNT)) | (!acc_last & full_cnt));
  end

`ifdef AXIS_I2S2_TX_ARB_FIXED_PRIO_EN
  // s0 always wins a simultaneous request, so no arbitration history is kept.
  always_comb begin
    win = !req[0];
  end
`else
  logic last_grant;

  // Remember the most recent winner so the other source goes first next time.
  always_ff @(posedge axis_clk or posedge axis_reset) begin
    if (axis_reset) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && (|req)) begin
      last_grant <= win;
    end
  end

  // Round-robin winner: on a tie the source that did not win last time gets the grant.
  always_comb begin
    if (req == 2'b11) begin
      win = !last_grant;
    end else begin
      win = req[1];
    end
  end
`endif

  // Packet-level grant FSM. The grant is held until the accept that ends the packet.
  always_ff @(posedge axis_clk or posedge axis_reset) begin
    if (axis_reset) begin
      state    <= IDLE;
      grant    <= 2'b00;
      word_cnt <= '0;
    end else if (state == IDLE) begin
      if (|req) begin
        grant    <= win ? 2'b10 : 2'b01;
        word_cnt <= '0;
        state    <= BUSY;
      end
    end else begin
      if (accept) begin
        if (pkt_end) begin
          grant    <= 2'b00;
          word_cnt <= '0;
          state    <= IDLE;
        end else begin
          word_cnt <= cnt_next;
        end
      end
    end
  end

  // Output slice. It loads on accept, empties on a downstream take, and holds while stalled.
  always_ff @(posedge axis_clk or posedge axis_reset) begin
    if (axis_reset) begin
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
      m_axis_last  <= 1'b0;
    end else if (accept) begin
      m_axis_valid <= 1'b1;
      m_axis_data  <= acc_data;
      m_axis_last  <= acc_last | full_cnt;
    end else if (m_axis_ready) begin
      m_axis_valid <= 1'b0;
    end
  end

  // Sticky length-error flag. A new error takes precedence over a clear in the same cycle.
  always_ff @(posedge axis_clk or posedge axis_reset) begin
    if (axis_reset) begin
      err_len <= 1'b0;
    end else if (err_set) begin
      err_len <= 1'b1;
    end else if (err_clear) begin
      err_len <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_i2s2_tx_arb.sv
// tb_axis_i2s2_tx_arb
// Scoreboard bench for axis_i2s2_tx_arb with the default parameters
// (DATA_WIDTH=32, PKT_WORDS=2). Source words are queued per source, and the
// expected output order is queued when stimulus is issued.
module tb_axis_i2s2_tx_arb;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } word_t;

  logic        axis_clk;
  logic        axis_reset;
  logic [31:0] s0_axis_data, s1_axis_data;
  logic        s0_axis_valid, s1_axis_valid;
  logic        s0_axis_ready, s1_axis_ready;
  logic        s0_axis_last, s1_axis_last;
  logic [1:0]  src_enable;
  logic [31:0] m_axis_data;
  logic        m_axis_valid;
  logic        m_axis_ready;
  logic        m_axis_last;
  logic [1:0]  grant;
  logic        err_len;
  logic        err_clear;

  word_t src_q0[$];
  word_t src_q1[$];
  word_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  axis_i2s2_tx_arb #(.DATA_WIDTH(32), .PKT_WORDS(2)) dut (
    .axis_clk      (axis_clk),
    .axis_reset    (axis_reset),
    .s0_axis_data  (s0_axis_data),
    .s0_axis_valid (s0_axis_valid),
    .s0_axis_ready (s0_axis_ready),
    .s0_axis_last  (s0_axis_last),
    .s1_axis_data  (s1_axis_data),
    .s1_axis_valid (s1_axis_valid),
    .s1_axis_ready (s1_axis_ready),
    .s1_axis_last  (s1_axis_last),
    .src_enable    (src_enable),
    .m_axis_data   (m_axis_data),
    .m_axis_valid  (m_axis_valid),
    .m_axis_ready  (m_axis_ready),
    .m_axis_last   (m_axis_last),
    .grant         (grant),
    .err_len       (err_len),
    .err_clear     (err_clear)
  );

  // Generate the clock at about 22.6 MHz.
  initial begin
    axis_clk = 1'b0;
    forever #22 axis_clk = ~axis_clk;
  end

  // Drive source 0 from its queue and advance after each handshake.
  initial begin : drive_s0
    logic hs;
    s0_axis_valid = 1'b0;
    s0_axis_data  = '0;
    s0_axis_last  = 1'b0;
    forever begin
      @(negedge axis_clk);
      hs = s0_axis_valid & s0_axis_ready;
      @(posedge axis_clk);
      #1;
      if (hs && src_q0.size() > 0) void'(src_q0.pop_front());
      if (src_q0.size() > 0) begin
        s0_axis_valid = 1'b1;
        s0_axis_data  = src_q0[0].data;
        s0_axis_last  = src_q0[0].last;
      end else begin
        s0_axis_valid = 1'b0;
        s0_axis_data  = '0;
        s0_axis_last  = 1'b0;
      end
    end
  end

  // Drive source 1 from its queue and advance after each handshake.
  initial begin : drive_s1
    logic hs;
    s1_axis_valid = 1'b0;
    s1_axis_data  = '0;
    s1_axis_last  = 1'b0;
    forever begin
      @(negedge axis_clk);
      hs = s1_axis_valid & s1_axis_ready;
      @(posedge axis_clk);
      #1;
      if (hs && src_q1.size() > 0) void'(src_q1.pop_front());
      if (src_q1.size() > 0) begin
        s1_axis_valid = 1'b1;
        s1_axis_data  = src_q1[0].data;
        s1_axis_last  = src_q1[0].last;
      end else begin
        s1_axis_valid = 1'b0;
        s1_axis_data  = '0;
        s1_axis_last  = 1'b0;
      end
    end
  end

  // Check every output handshake against the next expected word.
  initial begin : monitor
    word_t e;
    forever begin
      @(negedge axis_clk);
      if (m_axis_valid && m_axis_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL out_unexpected: got data=%h last=%b, required no output", m_axis_data, m_axis_last);
        end else begin
          e = exp_q.pop_front();
          if (m_axis_data !== e.data || m_axis_last !== e.last) begin
            n_fail++;
            $display("[TB] FAIL out_word: got data=%h last=%b, required data=%h last=%b",
                     m_axis_data, m_axis_last, e.data, e.last);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge axis_clk);
    #2;
  endtask

  task automatic push0(input logic [31:0] d, input logic l);
    src_q0.push_back('{data: d, last: l});
  endtask

  task automatic push1(input logic [31:0] d, input logic l);
    src_q1.push_back('{data: d, last: l});
  endtask

  task automatic expect_word(input logic [31:0] d, input logic l);
    exp_q.push_back('{data: d, last: l});
  endtask

  task automatic test_reset();
    axis_reset = 1'b1;
    src_enable = 2'b00;
    m_axis_ready = 1'b0;
    err_clear = 1'b0;
    repeat (3) @(negedge axis_clk);
    n_checks++;
    if ({m_axis_valid, m_axis_last, grant, err_len, s0_axis_ready, s1_axis_ready} !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got v=%b l=%b g=%b e=%b r0=%b r1=%b, required all 0",
               m_axis_valid, m_axis_last, grant, err_len, s0_axis_ready, s1_axis_ready);
    end
    n_checks++;
    if (m_axis_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got %h, required 00000000", m_axis_data);
    end
    step();
    axis_reset = 1'b0;
    repeat (2) @(negedge axis_clk);
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL idle_grant: got %b, required 00", grant);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] pat [12];
    int n;
    pat = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
            2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    step();
    src_enable = 2'b11;
    m_axis_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      push0(32'hA000_0000 + 32'(p * 2),     1'b0);
      push0(32'hA000_0001 + 32'(p * 2),     1'b1);
      push1(32'hB000_0000 + 32'(p * 2),     1'b0);
      push1(32'hB000_0001 + 32'(p * 2),     1'b1);
      expect_word(32'hA000_0000 + 32'(p * 2), 1'b0);
      expect_word(32'hA000_0001 + 32'(p * 2), 1'b1);
      expect_word(32'hB000_0000 + 32'(p * 2), 1'b0);
      expect_word(32'hB000_0001 + 32'(p * 2), 1'b1);
    end
    n = 0;
    @(negedge axis_clk);
    while (grant == 2'b00 && n < 20) begin
      @(negedge axis_clk);
      n++;
    end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge axis_clk);
      n_checks++;
      if (grant !== pat[i]) begin
        n_fail++;
        $display("[TB] FAIL rr_grant[%0d]: got %b, required %b", i, grant, pat[i]);
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge axis_clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL rr_drain: got %0d words left, required 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    int n;
    step();
    m_axis_ready = 1'b0;
    push0(32'h0012_3456, 1'b0);
    push0(32'h00AB_CDEF, 1'b1);
    expect_word(32'h0012_3456, 1'b0);
    expect_word(32'h00AB_CDEF, 1'b1);
    n = 0;
    @(negedge axis_clk);
    while (!m_axis_valid && n < 20) begin
      @(negedge axis_clk);
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge axis_clk);
      n_checks++;
      if (m_axis_valid !== 1'b1 || m_axis_data !== 32'h0012_3456 || m_axis_last !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL stall_hold[%0d]: got v=%b d=%h l=%b, required v=1 d=00123456 l=0",
                 k, m_axis_valid, m_axis_data, m_axis_last);
      end
      n_checks++;
      if (s0_axis_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL stall_ready[%0d]: got %b, required 0", k, s0_axis_ready);
      end
    end
    step();
    m_axis_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge axis_clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL stall_drain: got %0d words left, required 0", exp_q.size());
    end
  endtask

  task automatic test_short_packet();
    int n;
    step();
    src_enable = 2'b10;
    n_checks++;
    if (err_len !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL short_pre_err: got %b, required 0", err_len);
    end
    push1(32'hB0B0_0001, 1'b1);
    expect_word(32'hB0B0_0001, 1'b1);
    n = 0;
    @(negedge axis_clk);
    while (!err_len && n < 20) begin
      @(negedge axis_clk);
      n++;
    end
    n_checks++;
    if (err_len !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL short_err: got %b, required 1", err_len);
    end
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL short_release: got %b, required 00", grant);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge axis_clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL short_drain: got %0d words left, required 0", exp_q.size());
    end
    step();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    @(negedge axis_clk);
    n_checks++;
    if (err_len !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL short_clear: got %b, required 0", err_len);
    end
  endtask

  task automatic test_long_packet();
    int n;
    step();
    src_enable = 2'b01;
    push0(32'hC000_0001, 1'b0);
    push0(32'hC000_0002, 1'b0);
    push0(32'hC000_0003, 1'b0);
    push0(32'hC000_0004, 1'b1);
    expect_word(32'hC000_0001, 1'b0);
    expect_word(32'hC000_0002, 1'b1);
    expect_word(32'hC000_0003, 1'b0);
    expect_word(32'hC000_0004, 1'b1);
    n = 0;
    @(negedge axis_clk);
    while (!err_len && n < 20) begin
      @(negedge axis_clk);
      n++;
    end
    n_checks++;
    if (err_len !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL long_err: got %b, required 1", err_len);
    end
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL long_release: got %b, required 00", grant);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge axis_clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL long_drain: got %0d words left, required 0", exp_q.size());
    end
    step();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
  endtask

  task automatic test_enable();
    int n;
    step();
    src_enable = 2'b01;
    push0(32'hD000_0001, 1'b0);
    push0(32'hD000_0002, 1'b1);
    push1(32'hE000_0001, 1'b0);
    push1(32'hE000_0002, 1'b1);
    expect_word(32'hD000_0001, 1'b0);
    expect_word(32'hD000_0002, 1'b1);
    n = 0;
    @(negedge axis_clk);
    while (grant == 2'b00 && n < 20) begin
      @(negedge axis_clk);
      n++;
    end
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL en_grant: got %b, required 01", grant);
    end
    step();
    src_enable = 2'b00;
    for (int k = 0; k < 8; k++) begin
      @(negedge axis_clk);
      n_checks++;
      if (grant[1] !== 1'b0 || s1_axis_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL en_block[%0d]: got grant=%b r1=%b, required grant[1]=0 r1=0",
                 k, grant, s1_axis_ready);
      end
    end
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL en_idle: got %b, required 00", grant);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL en_drain: got %0d words left, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_packet();
    int n;
    step();
    src_enable = 2'b11;
    m_axis_ready = 1'b0;
    n = 0;
    @(negedge axis_clk);
    while (!m_axis_valid && n < 20) begin
      @(negedge axis_clk);
      n++;
    end
    n_checks++;
    if (m_axis_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_pre_valid: got %b, required 1", m_axis_valid);
    end
    step();
    axis_reset = 1'b1;
    #1;
    n_checks++;
    if ({m_axis_valid, m_axis_last, grant, s0_axis_ready, s1_axis_ready} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_async: got v=%b l=%b g=%b r0=%b r1=%b, required all 0",
               m_axis_valid, m_axis_last, grant, s0_axis_ready, s1_axis_ready);
    end
    n_checks++;
    if (m_axis_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL rst_async_data: got %h, required 00000000", m_axis_data);
    end
    src_q0.delete();
    src_q1.delete();
    step();
    step();
    push0(32'hF000_0001, 1'b0);
    push0(32'hF000_0002, 1'b1);
    push1(32'h6000_0001, 1'b0);
    push1(32'h6000_0002, 1'b1);
    expect_word(32'hF000_0001, 1'b0);
    expect_word(32'hF000_0002, 1'b1);
    expect_word(32'h6000_0001, 1'b0);
    expect_word(32'h6000_0002, 1'b1);
    m_axis_ready = 1'b1;
    axis_reset = 1'b0;
    n = 0;
    @(negedge axis_clk);
    while (grant == 2'b00 && n < 20) begin
      @(negedge axis_clk);
      n++;
    end
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL rst_first_grant: got %b, required 01", grant);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge axis_clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL rst_drain: got %0d words left, required 0", exp_q.size());
    end
  endtask

  // Run every scenario in order and print the summary.
  initial begin
    axis_reset   = 1'b1;
    src_enable   = 2'b00;
    m_axis_ready = 1'b0;
    err_clear    = 1'b0;
    $display("[TB] starting");
    test_reset();
    test_round_robin();
    test_stall();
    test_short_packet();
    test_long_packet();
    test_enable();
    test_reset_mid_packet();
    repeat (3) @(negedge axis_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
